hilo_muldiv: RTL and testbench

- Execute-stage consumer of the main decoder's HILO control outputs (write_hilo, aluop).
- Owns the HI and LO architectural registers and executes MTHI, MTLO, MFHI, MFLO, MULT and MULTU.
- Executes DIV and DIVU with a multi-cycle restoring divider that stalls the pipeline until the result is written.
- Sits beside the ALU in EX. Its mf_data output is muxed into the EX result for MFHI/MFLO.

---
 rtl/hilo_muldiv.sv | 167 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// HI/LO register file for the EX stage: MT/MF moves, single-cycle MULT/MULTU,
// and a 32-iteration restoring divider for DIV/DIVU that stalls the pipeline.
module hilo_muldiv #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              op_valid,
   input  logic [7:0]        aluop,
   input  logic              write_hilo,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   input  logic              flush,
   output logic              stall_o,
   output logic [DATA_W-1:0] mf_data,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int unsigned CNT_W  = $clog2(DATA_W);
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
   localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
   localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
   localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
   localparam logic [7:0] OP_MULT  = 8'b0001_1000;
   localparam logic [7:0] OP_MULTU = 8'b0001_1001;
   localparam logic [7:0] OP_DIV   = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] quo_q, quo_d;
   logic [DATA_W-1:0] dvsr_q, dvsr_d;
   logic              negq_q, negq_d;
   logic              negr_q, negr_d;
   logic              dz_q, dz_d;

   logic              is_div, is_mult, div_signed, mul_signed;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] rem_step, quo_step, abs_a, abs_b;
   logic [PROD_W-1:0] mul_a, mul_b, prod;

   // Operand decode and the shared 2W-bit multiplier (sign- or zero-extended inputs)
   always_comb begin
      is_div     = (aluop == OP_DIV) || (aluop == OP_DIVU);
      is_mult    = (aluop == OP_MULT) || (aluop == OP_MULTU);
      div_signed = (aluop == OP_DIV);
      mul_signed = (aluop == OP_MULT);
      mul_a      = {{DATA_W{mul_signed & src_a[DATA_W-1]}}, src_a};
      mul_b      = {{DATA_W{mul_signed & src_b[DATA_W-1]}}, src_b};
      prod       = mul_a * mul_b;
      abs_a      = (div_signed && src_a[DATA_W-1]) ? -src_a : src_a;
      abs_b      = (div_signed && src_b[DATA_W-1]) ? -src_b : src_b;
   end

   // One restoring step: shift in the next dividend bit, keep the subtraction if no borrow
   always_comb begin
      trial    = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvsr_q};
      rem_step = trial[DATA_W] ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]} : trial[DATA_W-1:0];
      quo_step = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
   end

   // Next-state and HI/LO write selection
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dz_d    = dz_q;
      stall_o = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (op_valid && !flush) begin
               if (is_div) begin
                  stall_o = 1'b1;
                  rem_d   = '0;
                  quo_d   = abs_a;
                  dvsr_d  = abs_b;
                  negq_d  = div_signed & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                  negr_d  = div_signed & src_a[DATA_W-1];
                  dz_d    = (src_b == '0);
                  count_d = '0;
                  state_d = ST_BUSY;
               end else if (is_mult) begin
                  hi_d = prod[PROD_W-1:DATA_W];
                  lo_d = prod[DATA_W-1:0];
               end else if (write_hilo && aluop == OP_MTHI) begin
                  hi_d = src_a;
               end else if (write_hilo && aluop == OP_MTLO) begin
                  lo_d = src_a;
               end
            end
         end
         ST_BUSY: begin
            stall_o = (count_q != CNT_LAST);
            rem_d   = rem_step;
            quo_d   = quo_step;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
               state_d = ST_IDLE;
               count_d = '0;
               hi_d    = negr_q ? -rem_step : rem_step;
               lo_d    = dz_q ? '1 : (negq_q ? -quo_step : quo_step);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Flush discards any pending write, including the final division result
      if (flush) begin
         state_d = ST_IDLE;
         count_d = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      mf_data = '0;
      if (aluop == OP_MFHI)      mf_data = hi_q;
      else if (aluop == OP_MFLO) mf_data = lo_q;
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hilo_muldiv;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
   localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
   localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
   localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
   localparam logic [7:0] OP_MULT  = 8'b0001_1000;
   localparam logic [7:0] OP_MULTU = 8'b0001_1001;
   localparam logic [7:0] OP_DIV   = 8'b0001_1010;
   localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

   logic        clk = 1'b0;
   logic        resetn, op_valid, write_hilo, flush;
   logic [7:0]  aluop;
   logic [31:0] src_a, src_b;
   logic        stall_o;
   logic [31:0] mf_data, hi_o, lo_o;

   hilo_muldiv #(.DATA_W(32)) dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .aluop(aluop),
      .write_hilo(write_hilo), .src_a(src_a), .src_b(src_b), .flush(flush),
      .stall_o(stall_o), .mf_data(mf_data), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      string       nm;
      logic [31:0] hi, lo, mf;
      logic        stall;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] ehi = 32'h0;
   logic [31:0] elo = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation tagged with the current cycle
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         if (hi_o !== e.hi || lo_o !== e.lo || mf_data !== e.mf || stall_o !== e.stall) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got hi=%h lo=%h mf=%h stall=%b, want hi=%h lo=%h mf=%h stall=%b",
                     e.nm, cyc, hi_o, lo_o, mf_data, stall_o, e.hi, e.lo, e.mf, e.stall);
         end
      end
   end

   // Present one cycle of inputs and queue what the outputs must show in that cycle
   task automatic drive(input string nm, input logic v, input logic [7:0] op, input logic wh,
                        input logic [31:0] a, input logic [31:0] b, input logic fl,
                        input logic rn, input logic st);
      exp_t e;
      @(posedge clk);
      #1;
      op_valid = v; aluop = op; write_hilo = wh; src_a = a; src_b = b;
      flush = fl; resetn = rn;
      e.cyc = cyc; e.nm = nm; e.hi = ehi; e.lo = elo; e.stall = st;
      e.mf  = (op == OP_MFHI) ? ehi : ((op == OP_MFLO) ? elo : 32'h0);
      sb.push_back(e);
   endtask

   task automatic idle(input string nm);
      drive(nm, 1'b0, OP_NOP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
   endtask

   // Full division: issue + 31 stalled BUSY cycles, final cycle unstalled, then MFLO
   task automatic do_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r);
      drive({nm, ":issue"}, 1'b1, op, 1'b0, a, b, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 31; i++)
         drive({nm, ":busy"}, 1'b1, op, 1'b0, a, b, 1'b0, 1'b1, 1'b1);
      drive({nm, ":last"}, 1'b1, op, 1'b0, a, b, 1'b0, 1'b1, 1'b0);
      ehi = r;
      elo = q;
      drive({nm, ":mflo"}, 1'b1, OP_MFLO, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      drive({nm, ":mfhi"}, 1'b1, OP_MFHI, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; op_valid = 1'b0; aluop = OP_NOP; write_hilo = 1'b0;
      src_a = 32'h0; src_b = 32'h0; flush = 1'b0;
      @(posedge clk);
      drive("reset", 1'b0, OP_NOP, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      idle("post_reset");

      // Moves
      drive("mthi", 1'b1, OP_MTHI, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b0);
      ehi = 32'h1234_5678;
      drive("mfhi", 1'b1, OP_MFHI, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      drive("mtlo_nowr", 1'b1, OP_MTLO, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, 1'b0);
      drive("mflo_nowr", 1'b1, OP_MFLO, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      drive("mtlo", 1'b1, OP_MTLO, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1, 1'b0);
      elo = 32'h0BAD_F00D;
      drive("mflo", 1'b1, OP_MFLO, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

      // Multiplies
      drive("mult", 1'b1, OP_MULT, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
      ehi = 32'hFFFF_FFFF; elo = 32'hFFFF_FFFA;
      drive("multu", 1'b1, OP_MULTU, 1'b0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
      ehi = 32'h0000_0002; elo = 32'hFFFF_FFFA;
      drive("mfhi_mul", 1'b1, OP_MFHI, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      drive("mult_flush", 1'b1, OP_MULT, 1'b0, 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
      drive("mthi_flush", 1'b1, OP_MTHI, 1'b1, 32'h5555_5555, 32'h0, 1'b1, 1'b1, 1'b0);
      idle("after_flush_writes");

      // Divides
      do_div("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      do_div("div_7_m2",  OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
      do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2);
      do_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
      do_div("divu_5_0",  OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      do_div("div_m9_0",  OP_DIV,  32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);

      // Issue suppressed by flush in the same cycle
      drive("div_issue_flush", 1'b1, OP_DIV, 1'b0, 32'd100, 32'd7, 1'b1, 1'b1, 1'b0);
      idle("div_issue_flush_next");

      // Flush at BUSY count=10
      drive("fl10:issue", 1'b1, OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++)
         drive("fl10:busy", 1'b1, OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
      drive("fl10:flush", 1'b1, OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b1, 1'b1, 1'b1);
      idle("fl10:after");
      idle("fl10:after2");

      // Flush on the final iteration suppresses the result write
      drive("fl31:issue", 1'b1, OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 31; i++)
         drive("fl31:busy", 1'b1, OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
      drive("fl31:flush", 1'b1, OP_DIVU, 1'b0, 32'd100, 32'd7, 1'b1, 1'b1, 1'b0);
      idle("fl31:after");

      // Reset mid-division
      drive("rst:issue", 1'b1, OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++)
         drive("rst:busy", 1'b1, OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b1);
      drive("rst:assert", 1'b1, OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b1);
      ehi = 32'h0; elo = 32'h0;
      idle("rst:after");
      for (int i = 0; i < 30; i++) idle("rst:quiet");

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
